// File: rtl/wddl_round_seq.sv
// wddl_round_seq: round sequencer for a WDDL (dual-rail precharge) AES datapath.
// Each round is a precharge phase with both rails at 0, then an evaluate phase
// with complementary rails. On the last evaluate cycle the true rail is captured
// as the new state and the returned rails are checked for complementarity.
module wddl_round_seq #(
    parameter int DW          = 128,
    parameter int ROUNDS      = 10,
    parameter int PRE_CYCLES  = 1,
    parameter int EVAL_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] din,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] dout,
    output logic          err,
    output logic          pre,
    output logic [3:0]    round,
    output logic          last,
    output logic [DW-1:0] dp_in_t,
    output logic [DW-1:0] dp_in_f,
    input  logic [DW-1:0] dp_out_t,
    input  logic [DW-1:0] dp_out_f
);

    // The phase counter has to reach the longer of the two phase lengths.
    localparam int MAXC = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] PRE_LAST   = CW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] EVAL_LAST  = CW'(EVAL_CYCLES - 1);
    localparam logic [3:0]    ROUND_LAST = 4'(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_fsm;
    state_t          w_fsm_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [3:0]      r_round;
    logic [3:0]      w_round_next;
    logic [DW-1:0]   r_state;
    logic [DW-1:0]   w_state_next;
    logic            r_err;
    logic            w_err_next;

    logic [DW-1:0]   w_bit_ok;
    logic            w_rails_ok;
    logic            w_evaluating;

    // Per-bit complementarity of the returned rail pair: a valid evaluate
    // value has exactly one of the two rails high.
    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_rail_chk
            assign w_bit_ok[gi] = dp_out_t[gi] ^ dp_out_f[gi];
        end
    endgenerate

    assign w_rails_ok   = &w_bit_ok;
    assign w_evaluating = (r_fsm == S_EVAL);

    // State register: FSM, phase counter, round, captured state and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= S_IDLE;
            r_cnt   <= '0;
            r_round <= '0;
            r_state <= '0;
            r_err   <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_next;
            r_cnt   <= w_cnt_next;
            r_round <= w_round_next;
            r_state <= w_state_next;
            r_err   <= w_err_next;
        end
    end

    // Next-state logic: phase sequencing, state capture and error accumulation.
    always_comb begin
        w_fsm_next   = r_fsm;
        w_cnt_next   = r_cnt;
        w_round_next = r_round;
        w_state_next = r_state;
        w_err_next   = r_err;

        case (r_fsm)
            S_IDLE: begin
                if (start) begin
                    w_state_next = din;
                    w_err_next   = 1'b0;
                    w_round_next = 4'd1;
                    w_cnt_next   = '0;
                    w_fsm_next   = S_PRE;
                end
            end

            S_PRE: begin
                if (r_cnt == PRE_LAST) begin
                    w_cnt_next = '0;
                    w_fsm_next = S_EVAL;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_EVAL: begin
                // The datapath outputs are only trusted on the final evaluate
                // cycle, after the settling window has elapsed.
                if (r_cnt == EVAL_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = dp_out_t;
                    if (!w_rails_ok) begin
                        w_err_next = 1'b1;
                    end
                    if (r_round == ROUND_LAST) begin
                        w_fsm_next = S_DONE;
                    end else begin
                        w_round_next = r_round + 4'd1;
                        w_fsm_next   = S_PRE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_DONE: begin
                w_round_next = '0;
                w_fsm_next   = S_IDLE;
            end

            default: begin
                w_fsm_next = S_IDLE;
            end
        endcase
    end

    // Moore output decode: every output is a function of registers only, so
    // the rails fall to 0/0 whenever the FSM leaves EVAL.
    always_comb begin
        busy    = (r_fsm != S_IDLE);
        done    = (r_fsm == S_DONE);
        pre     = !w_evaluating;
        dout    = r_state;
        err     = r_err;
        round   = r_round;
        last    = (r_round == ROUND_LAST);
        dp_in_t = w_evaluating ? r_state  : '0;
        dp_in_f = w_evaluating ? ~r_state : '0;
    end

endmodule

// File: tb/tb_wddl_round_seq.sv
// Testbench for wddl_round_seq: scoreboard of expected final states, a cycle
// model of the round/phase sequence, and a rail property check every cycle.
module tb_wddl_round_seq;

    localparam int DW    = 128;
    localparam int NR    = 10;
    localparam int NPRE  = 1;
    localparam int NEVAL = 2;
    localparam int P     = NPRE + NEVAL;
    localparam int DONEK = NR * P;
    localparam int FAULT_ROUND = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] din = '0;
    logic          busy, done, err, pre, last;
    logic [DW-1:0] dout, dp_in_t, dp_in_f, dp_out_t, dp_out_f;
    logic [3:0]    round;

    logic          start3 = 1'b0;
    logic [DW-1:0] din3 = '0;
    logic          busy3, done3, err3, pre3, last3;
    logic [DW-1:0] dout3, dp_in_t3, dp_in_f3, dp_out_t3, dp_out_f3;
    logic [3:0]    round3;

    bit mode_inv = 1'b0;
    bit fault_en = 1'b0;
    bit chk_en   = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    typedef struct {
        logic [DW-1:0] dout;
        bit            err;
    } exp_t;
    exp_t sb[$];

    bit active = 1'b0;
    bit cur_fault = 1'b0;
    int k = 0;
    int er;
    bit ep, eb, ed, el, ee;

    wddl_round_seq #(.DW(DW), .ROUNDS(NR), .PRE_CYCLES(NPRE), .EVAL_CYCLES(NEVAL)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din),
        .busy(busy), .done(done), .dout(dout), .err(err), .pre(pre),
        .round(round), .last(last), .dp_in_t(dp_in_t), .dp_in_f(dp_in_f),
        .dp_out_t(dp_out_t), .dp_out_f(dp_out_f)
    );

    wddl_round_seq #(.DW(DW), .ROUNDS(3), .PRE_CYCLES(NPRE), .EVAL_CYCLES(NEVAL)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .din(din3),
        .busy(busy3), .done(done3), .dout(dout3), .err(err3), .pre(pre3),
        .round(round3), .last(last3), .dp_in_t(dp_in_t3), .dp_in_f(dp_in_f3),
        .dp_out_t(dp_out_t3), .dp_out_f(dp_out_f3)
    );

    initial forever #5 clk = ~clk;

    // Datapath model for the main instance: identity or rail swap, with an
    // optional stuck-equal fault on bit 17 during the evaluate phase of round 4.
    always_comb begin
        dp_out_t = mode_inv ? dp_in_f : dp_in_t;
        dp_out_f = mode_inv ? dp_in_t : dp_in_f;
        if (fault_en && (round == 4'(FAULT_ROUND)) && !pre) begin
            dp_out_f[17] = dp_out_t[17];
        end
    end

    // The short-run instance always sees the rail-swapping datapath.
    assign dp_out_t3 = dp_in_f3;
    assign dp_out_f3 = dp_in_t3;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_busy",  128'(busy),  128'(0));
        check("rst_done",  128'(done),  128'(0));
        check("rst_dout",  dout,        128'(0));
        check("rst_err",   128'(err),   128'(0));
        check("rst_pre",   128'(pre),   128'(1));
        check("rst_round", 128'(round), 128'(0));
        check("rst_last",  128'(last),  128'(0));
        check("rst_dpt",   dp_in_t,     128'(0));
        check("rst_dpf",   dp_in_f,     128'(0));
    endtask

    task automatic run_one(input logic [DW-1:0] d, input bit inv, input bit fault, input bit poke);
        exp_t e;
        mode_inv = inv;
        fault_en = fault;
        din      = d;
        e.dout   = (inv && (NR % 2 == 1)) ? ~d : d;
        e.err    = fault;
        sb.push_back(e);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int e2 = 1; e2 <= DONEK + 2; e2++) begin
            @(posedge clk); #1;
            start = poke && (e2 == 3 || e2 == 5 || e2 == DONEK);
        end
        start    = 1'b0;
        fault_en = 1'b0;
    endtask

    // Per-cycle monitor: rail property, cycle-accurate sequence model and
    // scoreboard comparison when done is expected.
    always @(negedge clk) begin
        if (chk_en) begin
            if (pre) begin
                check("rail_t0", dp_in_t, 128'(0));
                check("rail_f0", dp_in_f, 128'(0));
            end else begin
                check("rail_cmp", dp_in_t ^ dp_in_f, {DW{1'b1}});
            end
            if (pre3) begin
                check("rail3_t0", dp_in_t3, 128'(0));
                check("rail3_f0", dp_in_f3, 128'(0));
            end else begin
                check("rail3_cmp", dp_in_t3 ^ dp_in_f3, {DW{1'b1}});
            end
        end
        if (!rst_n) begin
            active = 1'b0;
            sb.delete();
            if (chk_en) check("rst_nodone", 128'(done), 128'(0));
        end else begin
            if (active) begin
                k++;
                er = (k < DONEK) ? (k / P + 1) : ((k == DONEK) ? NR : 0);
                ep = (k < DONEK) ? ((k % P) < NPRE) : 1'b1;
                eb = (k <= DONEK);
                ed = (k == DONEK);
                el = (er == NR);
                ee = cur_fault && (k >= FAULT_ROUND * P);
                check("round", 128'(round), 128'(er));
                check("pre",   128'(pre),   128'(ep));
                check("busy",  128'(busy),  128'(eb));
                check("done",  128'(done),  128'(ed));
                check("last",  128'(last),  128'(el));
                check("err",   128'(err),   128'(ee));
                if (k == DONEK) begin
                    if (sb.size() == 0) begin
                        check("sb_empty", 128'(1), 128'(0));
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("dout", dout, e.dout);
                        check("err_done", 128'(err), 128'(e.err));
                        n_txn++;
                        $display("txn %0d: dout=%h err=%0d done at cycle %0d", n_txn, dout, err, k);
                    end
                end
                if (k == DONEK + 1) active = 1'b0;
            end
            if (!active && start && !busy) begin
                active    = 1'b1;
                k         = -1;
                cur_fault = (sb.size() > 0) ? sb[0].err : 1'b0;
            end
        end
    end

    initial begin
        logic [DW-1:0] d0;
        d0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

        // Reset and idle behaviour.
        repeat (3) @(posedge clk);
        #1 check_reset();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_reset();
        end

        // Identity datapath, defaults.
        run_one(d0, 1'b0, 1'b0, 1'b0);

        // Rail-swapping datapath on the 3-round instance: dout = ~din.
        din3 = d0;
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        repeat (3 * P - 1) @(posedge clk);
        #1 check("r3_done_early", 128'(done3), 128'(0));
        @(posedge clk);
        #1 check("r3_done", 128'(done3), 128'(1));
        check("r3_dout", dout3, ~d0);
        check("r3_err",  128'(err3), 128'(0));
        $display("txn r3: dout=%h err=%0d", dout3, err3);
        @(posedge clk);
        #1 check("r3_idle", 128'(busy3), 128'(0));

        // Rail swap on the 10-round instance: even count returns din.
        run_one(128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3, 1'b1, 1'b0, 1'b0);

        // Fault in round 4: err rises at capture and is sticky through done.
        run_one(128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 1'b0, 1'b1, 1'b0);

        // Next run clears err; start pulses in PRE, EVAL and DONE are ignored.
        run_one(128'h13579BDF_2468ACE0_FEDCBA98_76543210, 1'b0, 1'b0, 1'b1);

        // Reset during round 5 EVAL aborts the run with no done.
        mode_inv = 1'b0;
        din = d0;
        sb.push_back('{dout: d0, err: 1'b0});
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4 * P + 1) @(posedge clk);
        #1 check("abort_round", 128'(round), 128'(5));
        check("abort_eval", 128'(pre), 128'(0));
        rst_n = 1'b0;
        #1 check_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_reset();
        end
        rst_n = 1'b1;

        // A new run after the abort completes normally.
        run_one(d0, 1'b0, 1'b0, 1'b0);

        check("sb_left", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
